// File: rtl/ky32_skid_reg.sv
// Two-entry ready/valid skid register between KY32 pipeline stages; one-cycle latency.
// Full throughput under backpressure. in_ready is a flop, so out_ready has no combinational path to it.
module ky32_skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] skid_data;

    logic in_xfer;
    logic out_xfer;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;

        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain path can fire
                if (out_xfer) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase

        // Branch redirect: drop everything held and anything offered this cycle
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != FULL);
            out_valid <= (state_nxt != EMPTY);
            if (load_main_in) begin
                out_data <= in_data;
            end else if (load_main_skid) begin
                out_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_ky32_skid_reg.sv
// Directed and random-backpressure bench for ky32_skid_reg with an in-order scoreboard.
module tb_ky32_skid_reg;

    logic        clk;
    logic        clr;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int          errs;
    int          checks;
    logic [31:0] sb_q[$];
    logic        prev_stall;
    logic [31:0] prev_data;

    ky32_skid_reg #(.WIDTH(32)) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Observe the handshakes that the coming rising edge will perform
    always @(negedge clk) begin
        if (clr) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_extra_beat", 32'(sb_q.size()), 1);
                end else begin
                    chk("sb_data", out_data, sb_q[0]);
                    void'(sb_q.pop_front());
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back(in_data);
            end
            prev_stall = out_valid && !out_ready && !flush;
            prev_data  = out_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int budget;
        errs       = 0;
        checks     = 0;
        prev_stall = 1'b0;
        prev_data  = '0;

        // Reset with a beat offered and downstream ready: nothing may be taken
        clr       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEADBEEF;
        out_ready = 1'b1;
        cyc();
        cyc();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_data", out_data, 32'h0);
        cyc();
        chk("rst_no_beat", 32'(out_valid), 0);

        // Streaming at full rate
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            cyc();
            chk("stream_valid", 32'(out_valid), 1);
            chk("stream_data", out_data, 32'(i));
            chk("stream_in_ready", 32'(in_ready), 1);
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_drained", 32'(out_valid), 0);

        // Skid fill and drain
        in_valid = 1'b1;
        in_data  = 32'hA;
        cyc();
        in_data   = 32'hB;
        out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_out_data", out_data, 32'hA);
        cyc();
        chk("full_hold_data", out_data, 32'hA);
        chk("full_hold_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        cyc();
        chk("drain_b_data", out_data, 32'hB);
        chk("drain_b_valid", 32'(out_valid), 1);
        chk("drain_in_ready", 32'(in_ready), 1);
        cyc();
        chk("drain_empty", 32'(out_valid), 0);

        // Random traffic and backpressure
        accepted = 0;
        budget   = 0;
        while (accepted < 1000 && budget < 20000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) accepted++;
            cyc();
            budget++;
        end
        chk("rand_budget", 32'(accepted >= 1000), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("rand_sb_empty", 32'(sb_q.size()), 0);
        chk("rand_out_idle", 32'(out_valid), 0);

        // Flush while FULL, with a new beat offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        cyc();
        in_data = 32'h22;
        cyc();
        chk("flush_pre_full", 32'(in_ready), 0);
        flush   = 1'b1;
        in_data = 32'h33;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        repeat (3) begin
            cyc();
            chk("flush_nothing_out", 32'(out_valid), 0);
        end

        // Flush while EMPTY discards a beat even though in_ready is high
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h44;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_empty_discard", 32'(out_valid), 0);
        cyc();
        chk("flush_empty_still", 32'(out_valid), 0);

        // clr and flush together in ONE: clr wins and zeroes out_data
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        cyc();
        in_valid = 1'b0;
        chk("one_data", out_data, 32'h55);
        clr       = 1'b1;
        flush     = 1'b1;
        out_ready = 1'b1;
        cyc();
        clr   = 1'b0;
        flush = 1'b0;
        chk("clr_flush_data", out_data, 32'h0);
        chk("clr_flush_valid", 32'(out_valid), 0);
        chk("clr_flush_in_ready", 32'(in_ready), 1);
        cyc();
        chk("clr_flush_idle", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
